// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth multiplier: recoded operation
// encodings and the controller state type.
package booth_pkg;

  typedef enum logic [2:0] {
    OP_ZERO = 3'b000,
    OP_P1   = 3'b001,
    OP_P2   = 3'b010,
    OP_M1   = 3'b011,
    OP_M2   = 3'b100
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/booth_mult_seq_if.sv
// Start/busy/done handshake and operand/result bus of the sequential multiplier.
interface booth_mult_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic [WIDTH-1:0] product_lo;
  logic [WIDTH-1:0] product_hi;
  logic             overflow;
  logic             busy;
  logic             done;

  modport master (
    output start, multiplicand, multiplier,
    input  product_lo, product_hi, overflow, busy, done
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output product_lo, product_hi, overflow, busy, done
  );
endinterface

// File: rtl/booth_decode.sv
// Radix-4 Booth recoder: maps a 3-bit multiplier window {q[i+1], q[i], q[i-1]}
// to one of 0, +M, +2M, -M, -2M.
module booth_decode
  import booth_pkg::*;
(
  input  logic [2:0] booth_bits,
  output op_t        op
);

  // window-to-operation lookup
  always_comb begin
    op = OP_ZERO;
    case (booth_bits)
      3'b000:  op = OP_ZERO;
      3'b001:  op = OP_P1;
      3'b010:  op = OP_P1;
      3'b011:  op = OP_P2;
      3'b100:  op = OP_M2;
      3'b101:  op = OP_M1;
      3'b110:  op = OP_M1;
      3'b111:  op = OP_ZERO;
      default: op = OP_ZERO;
    endcase
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential signed radix-4 Booth multiplier: WIDTH/2 add-and-shift iterations
// per product, with a start/busy/done handshake.
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  booth_mult_seq_if.slave   bus
);

  localparam int CW = $clog2(WIDTH / 2 + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH / 2);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t              state_r;
  logic [WIDTH+1:0]    acc_r;
  logic [WIDTH:0]      mq_r;
  logic [WIDTH+1:0]    m_r;
  logic [CW-1:0]       cnt_r;
  logic [WIDTH-1:0]    prod_lo_r;
  logic [WIDTH-1:0]    prod_hi_r;
  logic                ovf_r;
  logic                busy_r;
  logic                done_r;

  op_t                 op_s;
  logic                accept_s;
  logic [WIDTH+1:0]    addend_s;
  logic [WIDTH+1:0]    sum_s;
  logic signed [2*WIDTH+2:0] shifted_s;
  logic [WIDTH-1:0]    lo_s;
  logic [WIDTH-1:0]    hi_s;
  logic                ovf_s;

  booth_decode u_decode (
    .booth_bits (mq_r[2:0]),
    .op         (op_s)
  );

  assign accept_s = bus.start && ((state_r == ST_IDLE) || (state_r == ST_DONE));

  // addend selection; negation is two's complement at WIDTH+2 bits
  always_comb begin
    addend_s = {(WIDTH+2){1'b0}};
    case (op_s)
      OP_ZERO: addend_s = {(WIDTH+2){1'b0}};
      OP_P1:   addend_s = m_r;
      OP_P2:   addend_s = {m_r[WIDTH:0], 1'b0};
      OP_M1:   addend_s = ~m_r + {{(WIDTH+1){1'b0}}, 1'b1};
      OP_M2:   addend_s = ~{m_r[WIDTH:0], 1'b0} + {{(WIDTH+1){1'b0}}, 1'b1};
      default: addend_s = {(WIDTH+2){1'b0}};
    endcase
  end

  assign sum_s     = acc_r + addend_s;
  assign shifted_s = $signed({sum_s, mq_r}) >>> 2;
  // after the last shift the product is {acc[WIDTH-1:0], mq[WIDTH:1]}
  assign lo_s      = shifted_s[WIDTH:1];
  assign hi_s      = shifted_s[2*WIDTH:WIDTH+1];
  assign ovf_s     = (hi_s != {WIDTH{lo_s[WIDTH-1]}});

  // controller, datapath registers and registered handshake/result outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      acc_r     <= {(WIDTH+2){1'b0}};
      mq_r      <= {(WIDTH+1){1'b0}};
      m_r       <= {(WIDTH+2){1'b0}};
      cnt_r     <= {CW{1'b0}};
      prod_lo_r <= {WIDTH{1'b0}};
      prod_hi_r <= {WIDTH{1'b0}};
      ovf_r     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else if (accept_s) begin
      state_r <= ST_RUN;
      acc_r   <= {(WIDTH+2){1'b0}};
      mq_r    <= {bus.multiplier, 1'b0};
      m_r     <= {{2{bus.multiplicand[WIDTH-1]}}, bus.multiplicand};
      cnt_r   <= CNT_INIT;
      busy_r  <= 1'b1;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
        ST_RUN: begin
          acc_r <= shifted_s[2*WIDTH+2:WIDTH+1];
          mq_r  <= shifted_s[WIDTH:0];
          cnt_r <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            state_r   <= ST_DONE;
            prod_lo_r <= lo_s;
            prod_hi_r <= hi_s;
            ovf_r     <= ovf_s;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
          end else begin
            busy_r <= 1'b1;
            done_r <= 1'b0;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.product_lo = prod_lo_r;
  assign bus.product_hi = prod_hi_r;
  assign bus.overflow   = ovf_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed and small random checks of booth_mult_seq against hand-computed
// values and a 64-bit signed reference.
module tb_booth_mult_seq;

  localparam int WIDTH = 32;

  logic clock;
  logic reset_n;
  int   errors;
  int   checks;

  booth_mult_seq_if #(.WIDTH(WIDTH)) bus ();

  booth_mult_seq #(.WIDTH(WIDTH)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // drive one request and step past its accept edge
  task automatic issue(input logic [31:0] m, input logic [31:0] q);
    bus.start        = 1'b1;
    bus.multiplicand = m;
    bus.multiplier   = q;
    tick();
    bus.start = 1'b0;
  endtask

  // wait for done with a cycle budget; returns cycles counted and busy samples
  task automatic wait_done(output int cyc, output int busy_cnt);
    cyc      = 0;
    busy_cnt = (bus.busy === 1'b1) ? 1 : 0;
    while (bus.done !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
      if (bus.busy === 1'b1) busy_cnt++;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] m, input logic [31:0] q,
                        input logic [31:0] exp_lo, input logic [31:0] exp_hi, input logic exp_ovf);
    int cyc;
    int bc;
    issue(m, q);
    wait_done(cyc, bc);
    check({tag, " latency"}, 64'(cyc), 64'd16);
    check({tag, " lo"}, {32'd0, bus.product_lo}, {32'd0, exp_lo});
    check({tag, " hi"}, {32'd0, bus.product_hi}, {32'd0, exp_hi});
    check({tag, " ovf"}, {63'd0, bus.overflow}, {63'd0, exp_ovf});
  endtask

  initial begin
    int cyc;
    int bc;
    logic [31:0] rm;
    logic [31:0] rq;
    logic signed [63:0] ref_p;
    logic ref_ovf;

    errors           = 0;
    checks           = 0;
    reset_n          = 1'b0;
    bus.start        = 1'b0;
    bus.multiplicand = 32'd0;
    bus.multiplier   = 32'd0;
    #12;
    check("reset busy", {63'd0, bus.busy}, 64'd0);
    check("reset done", {63'd0, bus.done}, 64'd0);
    check("reset product", {bus.product_hi, bus.product_lo}, 64'd0);
    check("reset ovf", {63'd0, bus.overflow}, 64'd0);
    reset_n = 1'b1;
    tick();

    // 1: 7 * -3, with busy/done timing
    issue(32'd7, 32'hFFFF_FFFD);
    check("t1 busy after accept", {63'd0, bus.busy}, 64'd1);
    wait_done(cyc, bc);
    check("t1 latency", 64'(cyc), 64'd16);
    check("t1 busy cycles", 64'(bc), 64'd16);
    check("t1 lo", {32'd0, bus.product_lo}, 64'h0000_0000_FFFF_FFEB);
    check("t1 hi", {32'd0, bus.product_hi}, 64'h0000_0000_FFFF_FFFF);
    check("t1 ovf", {63'd0, bus.overflow}, 64'd0);
    tick();
    check("t1 done one cycle", {63'd0, bus.done}, 64'd0);
    check("t1 result held", {32'd0, bus.product_lo}, 64'h0000_0000_FFFF_FFEB);

    // 2-4: boundary operands
    run_op("t2 minneg", 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h4000_0000, 1'b1);
    run_op("t3 m1xm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0);
    run_op("t4 maxx2", 32'h7FFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 32'h0000_0000, 1'b1);

    // 5: start during RUN ignored, then back-to-back accept from DONE
    issue(32'd5, 32'd6);
    bus.multiplicand = 32'd1;
    bus.multiplier   = 32'd1;
    for (int i = 0; i < 4; i++) tick();
    bus.start        = 1'b1;
    bus.multiplicand = 32'd9;
    bus.multiplier   = 32'd9;
    tick();
    bus.start = 1'b0;
    check("t5 product held in run", {32'd0, bus.product_lo}, 64'h0000_0000_FFFF_FFFE);
    wait_done(cyc, bc);
    check("t5 latency", 64'(cyc), 64'd11);
    check("t5 lo", {32'd0, bus.product_lo}, 64'd30);
    issue(32'd3, 32'd4);
    check("t5 b2b busy", {63'd0, bus.busy}, 64'd1);
    check("t5 b2b old product", {32'd0, bus.product_lo}, 64'd30);
    wait_done(cyc, bc);
    check("t5 b2b latency", 64'(cyc), 64'd16);
    check("t5 b2b lo", {32'd0, bus.product_lo}, 64'd12);
    check("t5 b2b hi", {32'd0, bus.product_hi}, 64'd0);

    // 6: asynchronous reset mid-operation
    issue(32'd5, 32'd6);
    for (int i = 0; i < 7; i++) tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("t6 busy", {63'd0, bus.busy}, 64'd0);
    check("t6 done", {63'd0, bus.done}, 64'd0);
    check("t6 product", {bus.product_hi, bus.product_lo}, 64'd0);
    check("t6 ovf", {63'd0, bus.overflow}, 64'd0);
    tick();
    reset_n = 1'b1;
    tick();
    run_op("t6 after", 32'hFFFF_FFF8, 32'd8, 32'hFFFF_FFC0, 32'hFFFF_FFFF, 1'b0);

    // random signed pairs against a 64-bit reference
    for (int n = 0; n < 200; n++) begin
      rm = $urandom();
      rq = $urandom();
      if (n % 4 == 1) rm = {{20{rm[31]}}, rm[11:0]};
      ref_p   = $signed(rm) * $signed(rq);
      ref_ovf = (ref_p[63:32] != {32{ref_p[31]}});
      issue(rm, rq);
      wait_done(cyc, bc);
      check("rand latency", 64'(cyc), 64'd16);
      check("rand product", {bus.product_hi, bus.product_lo}, ref_p);
      check("rand ovf", {63'd0, bus.overflow}, {63'd0, ref_ovf});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
